// File: rtl/reaction_stats.sv
// Reaction-time statistics: last, best and rolling 8-trial average, mode-selected for bin2bcd.
// Optional best tracking is compiled in with `define RSTATS_BEST_EN.
module reaction_stats #(
   parameter int WIDTH  = 14,
   parameter int MAX_MS = 9999
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             react_valid,
   input  logic [WIDTH-1:0] react,
   input  logic             clear,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] disp,
   output logic [3:0]       count,
   output logic [3:0]       rejects,
   output logic             new_best,
   output logic             busy,
   output logic             drop
);

   localparam int SUM_W = WIDTH + 3;
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_MS);

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t           state;
   logic [WIDTH-1:0] last_q;
   logic [WIDTH-1:0] avg_q;
   logic [WIDTH-1:0] best_view;
   logic [WIDTH-1:0] buf_q [8];
   logic [2:0]       wptr;
   logic [SUM_W-1:0] sum_q;
   logic [SUM_W-1:0] div_q;
   logic [3:0]       div_r;
   logic [3:0]       div_d;
   logic [4:0]       div_cnt;

   logic             last_step;
   logic             ready;
   logic             accept;
   logic             take;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] evicted;
   logic [SUM_W-1:0] sum_next;
   logic [3:0]       count_next;
   logic [4:0]       shifted;
   logic             ge;
   logic [3:0]       r_next;
   logic [SUM_W-1:0] q_next;

   // The final divider cycle also counts as ready, so a new trial may start on the completing edge.
   always_comb begin
      busy       = (state == S_DIV);
      last_step  = busy && (div_cnt == 5'd1);
      ready      = !busy || last_step;
      accept     = react_valid && ready && !clear;
      take       = accept && (react != '0);
      sample     = (react > MAX_V) ? MAX_V : react;
      evicted    = (count == 4'd8) ? buf_q[wptr] : '0;
      sum_next   = sum_q + SUM_W'(sample) - SUM_W'(evicted);
      count_next = (count == 4'd8) ? count : count + 4'd1;
      shifted    = {div_r, div_q[SUM_W-1]};
      ge         = (shifted >= {1'b0, div_d});
      r_next     = ge ? 4'(shifted - {1'b0, div_d}) : shifted[3:0];
      q_next     = {div_q[SUM_W-2:0], ge};
   end

`ifdef RSTATS_BEST_EN
   logic [WIDTH-1:0] best_q;

   // Samples are never zero, so best_q == 0 doubles as "no best yet".
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         best_q   <= '0;
         new_best <= 1'b0;
      end else if (clear) begin
         best_q   <= '0;
         new_best <= 1'b0;
      end else begin
         new_best <= 1'b0;
         if (take && ((best_q == '0) || (sample < best_q))) begin
            best_q   <= sample;
            new_best <= 1'b1;
         end
      end
   end

   always_comb best_view = best_q;
`else
   always_comb begin
      best_view = last_q;
      new_best  = 1'b0;
   end
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         last_q  <= '0;
         avg_q   <= '0;
         wptr    <= '0;
         sum_q   <= '0;
         count   <= '0;
         rejects <= '0;
         drop    <= 1'b0;
         disp    <= '0;
         div_q   <= '0;
         div_r   <= '0;
         div_d   <= '0;
         div_cnt <= '0;
         for (int unsigned i = 0; i < 8; i++) buf_q[i] <= '0;
      end else if (clear) begin
         state   <= S_IDLE;
         last_q  <= '0;
         avg_q   <= '0;
         wptr    <= '0;
         sum_q   <= '0;
         count   <= '0;
         rejects <= '0;
         drop    <= 1'b0;
         disp    <= '0;
         div_q   <= '0;
         div_r   <= '0;
         div_d   <= '0;
         div_cnt <= '0;
         for (int unsigned i = 0; i < 8; i++) buf_q[i] <= '0;
      end else begin
         if (react_valid && !ready) drop <= 1'b1;
         if (accept && (react == '0) && (rejects != 4'd15)) rejects <= rejects + 4'd1;

         if (state == S_DIV) begin
            div_q   <= q_next;
            div_r   <= r_next;
            div_cnt <= div_cnt - 5'd1;
            if (last_step) begin
               state <= S_IDLE;
               avg_q <= (q_next > SUM_W'(MAX_V)) ? MAX_V : q_next[WIDTH-1:0];
            end
         end

         // A new trial overrides the divider registers written just above.
         if (take) begin
            last_q      <= sample;
            buf_q[wptr] <= sample;
            wptr        <= wptr + 3'd1;
            sum_q       <= sum_next;
            count       <= count_next;
            state       <= S_DIV;
            div_q       <= sum_next;
            div_r       <= '0;
            div_d       <= count_next;
            div_cnt     <= 5'd17;
         end

         case (mode)
            2'd0:    disp <= last_q;
            2'd1:    disp <= best_view;
            2'd2:    disp <= avg_q;
            default: disp <= {{(WIDTH-4){1'b0}}, count};
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_stats.sv
// Self-checking bench for reaction_stats against a queue-based model of the 8-trial window.
module tb_reaction_stats;

`ifdef RSTATS_BEST_EN
   localparam bit BEST_EN = 1'b1;
`else
   localparam bit BEST_EN = 1'b0;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        react_valid = 1'b0;
   logic [13:0] react = '0;
   logic        clear = 1'b0;
   logic [1:0]  mode = '0;
   logic [13:0] disp;
   logic [3:0]  count;
   logic [3:0]  rejects;
   logic        new_best;
   logic        busy;
   logic        drop;

   int n_cmp = 0;
   int n_fail = 0;

   int q[$];
   int m_last, m_best, m_rej, m_nb;

   reaction_stats #(.WIDTH(14), .MAX_MS(9999)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .react_valid(react_valid), .react(react),
      .clear(clear), .mode(mode), .disp(disp), .count(count), .rejects(rejects),
      .new_best(new_best), .busy(busy), .drop(drop)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required earlier finish");
      $fatal(1, "timeout");
   end

   function automatic void model_clear();
      q.delete();
      m_last = 0; m_best = 0; m_rej = 0; m_nb = 0;
   endfunction

   function automatic void model_push(input int v);
      int s;
      m_nb = 0;
      if (v == 0) begin
         if (m_rej < 15) m_rej++;
      end else begin
         s = (v > 9999) ? 9999 : v;
         m_last = s;
         q.push_back(s);
         if (q.size() > 8) q.delete(0);
         if (BEST_EN && (m_best == 0 || s < m_best)) begin
            m_best = s;
            m_nb = 1;
         end
      end
   endfunction

   function automatic int m_avg();
      int s = 0;
      foreach (q[i]) s += q[i];
      return (q.size() == 0) ? 0 : s / q.size();
   endfunction

   function automatic int exp_disp(input int m);
      case (m)
         0: return m_last;
         1: return BEST_EN ? m_best : m_last;
         2: return m_avg();
         default: return q.size();
      endcase
   endfunction

   task automatic pulse(input int v);
      react = v[13:0];
      react_valid = 1'b1;
      @(posedge CLOCK_50); #1;
      react_valid = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      do begin
         @(posedge CLOCK_50); #1;
         cyc++;
      end while (busy && cyc < 40);
   endtask

   task automatic show(input int m);
      mode = 2'(m);
      @(posedge CLOCK_50); #1;
   endtask

   task automatic clear_stats();
      clear = 1'b1;
      @(posedge CLOCK_50); #1;
      clear = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      #1 reset = 1'b0;
      model_clear();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (rejects !== 4'd0) begin n_fail++; $display("FAIL reset_rejects got %0d want 0", rejects); end
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", drop); end
      n_cmp++; if (new_best !== 1'b0) begin n_fail++; $display("FAIL reset_new_best got %b want 0", new_best); end
      for (int m = 0; m < 4; m++) begin
         show(m);
         n_cmp++; if (disp !== 14'd0) begin n_fail++; $display("FAIL reset_disp mode %0d got %0d want 0", m, disp); end
      end
   endtask

   task automatic test_basic();
      int vals[3] = '{300, 250, 400};
      int cyc;
      foreach (vals[i]) begin
         pulse(vals[i]);
         model_push(vals[i]);
         n_cmp++; if (new_best !== 1'(m_nb)) begin n_fail++; $display("FAIL basic_new_best sample %0d got %b want %0d", vals[i], new_best, m_nb); end
         n_cmp++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL basic_count got %0d want %0d", count, q.size()); end
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", busy); end
         wait_idle(cyc);
         n_cmp++; if (cyc != 17) begin n_fail++; $display("FAIL basic_div_latency got %0d want 17", cyc); end
      end
      show(2);
      n_cmp++; if (disp !== 14'(m_avg())) begin n_fail++; $display("FAIL basic_avg got %0d want %0d", disp, m_avg()); end
      show(1);
      n_cmp++; if (disp !== 14'(exp_disp(1))) begin n_fail++; $display("FAIL basic_best got %0d want %0d", disp, exp_disp(1)); end
   endtask

   task automatic test_wrap();
      int cyc;
      clear_stats();
      for (int i = 1; i <= 10; i++) begin
         pulse(i * 100);
         model_push(i * 100);
         wait_idle(cyc);
      end
      n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL wrap_count got %0d want 8", count); end
      show(2);
      n_cmp++; if (disp !== 14'(m_avg())) begin n_fail++; $display("FAIL wrap_avg got %0d want %0d", disp, m_avg()); end
      show(0);
      n_cmp++; if (disp !== 14'd1000) begin n_fail++; $display("FAIL wrap_last got %0d want 1000", disp); end
   endtask

   task automatic test_false_start();
      int cyc;
      clear_stats();
      repeat (3) begin
         pulse(0);
         model_push(0);
         n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy got %b want 0", busy); end
      end
      pulse(12000);
      model_push(12000);
      wait_idle(cyc);
      n_cmp++; if (rejects !== 4'(m_rej)) begin n_fail++; $display("FAIL false_start_rejects got %0d want %0d", rejects, m_rej); end
      n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL false_start_count got %0d want 1", count); end
      show(0);
      n_cmp++; if (disp !== 14'd9999) begin n_fail++; $display("FAIL false_start_last got %0d want 9999", disp); end
      show(2);
      n_cmp++; if (disp !== 14'd9999) begin n_fail++; $display("FAIL false_start_avg got %0d want 9999", disp); end
   endtask

   task automatic test_drop();
      int cyc;
      clear_stats();
      pulse(700);
      model_push(700);
      repeat (4) @(posedge CLOCK_50);
      pulse(1234);
      n_cmp++; if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_set got %b want 1", drop); end
      n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL drop_count got %0d want 1", count); end
      wait_idle(cyc);
      show(2);
      n_cmp++; if (disp !== 14'(m_avg())) begin n_fail++; $display("FAIL drop_avg got %0d want %0d", disp, m_avg()); end
      clear_stats();
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL clear_drop got %b want 0", drop); end
      n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", count); end
      show(0);
      n_cmp++; if (disp !== 14'd0) begin n_fail++; $display("FAIL clear_last got %0d want 0", disp); end
      clear = 1'b1;
      pulse(55);
      clear = 1'b0;
      n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL clear_wins_count got %0d want 0", count); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_wins_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_div();
      int cyc;
      mode = 2'd0;
      pulse(800);
      model_push(800);
      repeat (8) @(posedge CLOCK_50);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
      n_cmp++; if (disp !== 14'd0) begin n_fail++; $display("FAIL async_reset_disp got %0d want 0", disp); end
      @(posedge CLOCK_50); #1 reset = 1'b0;
      model_clear();
      pulse(500);
      model_push(500);
      wait_idle(cyc);
      n_cmp++; if (cyc != 17) begin n_fail++; $display("FAIL post_reset_latency got %0d want 17", cyc); end
      show(2);
      n_cmp++; if (disp !== 14'd500) begin n_fail++; $display("FAIL post_reset_avg got %0d want 500", disp); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      clear_stats();
      mode = 2'd2;
      pulse(600);
      model_push(600);
      repeat (16) @(posedge CLOCK_50);
      #1 pulse(200);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
      n_cmp++; if (drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got %b want 0", drop); end
      n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", count); end
      @(posedge CLOCK_50); #1;
      n_cmp++; if (disp !== 14'(m_avg())) begin n_fail++; $display("FAIL b2b_first_avg got %0d want %0d", disp, m_avg()); end
      model_push(200);
      wait_idle(cyc);
      n_cmp++; if (cyc != 16) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 16", cyc); end
      show(2);
      n_cmp++; if (disp !== 14'(m_avg())) begin n_fail++; $display("FAIL b2b_second_avg got %0d want %0d", disp, m_avg()); end
   endtask

   task automatic test_random();
      int v, r, m, cyc;
      clear_stats();
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 99);
         if (r < 10) v = 0;
         else if (r < 20) v = $urandom_range(10000, 16383);
         else v = $urandom_range(1, 9999);
         pulse(v);
         model_push(v);
         n_cmp++; if (new_best !== 1'(m_nb)) begin n_fail++; $display("FAIL rand_new_best sample %0d got %b want %0d", v, new_best, m_nb); end
         n_cmp++; if (rejects !== 4'(m_rej)) begin n_fail++; $display("FAIL rand_rejects got %0d want %0d", rejects, m_rej); end
         if (v != 0) begin
            wait_idle(cyc);
            n_cmp++; if (cyc != 17) begin n_fail++; $display("FAIL rand_latency got %0d want 17", cyc); end
         end else begin
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_reject_busy got %b want 0", busy); end
         end
         m = $urandom_range(0, 3);
         show(m);
         n_cmp++; if (disp !== 14'(exp_disp(m))) begin n_fail++; $display("FAIL rand_disp mode %0d got %0d want %0d", m, disp, exp_disp(m)); end
         n_cmp++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rand_count got %0d want %0d", count, q.size()); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_false_start();
      test_drop();
      test_reset_mid_div();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
